// File: rtl/neo_pkg.sv
// Shared types and default timing for the NeoPixel driver.
package neo_pkg;

  // Byte slot within a pixel; NONE marks a write that must be dropped.
  typedef enum logic [1:0] {
    GREEN = 2'd0,
    RED   = 2'd1,
    BLUE  = 2'd2,
    NONE  = 2'd3
  } color_e;

  // Driver FSM: line high, line low, inter-frame latch gap.
  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow,
    StLatch
  } state_e;

  // Defaults for a 50 MHz clock.
  localparam int unsigned T0H        = 18;
  localparam int unsigned T1H        = 35;
  localparam int unsigned BIT_PERIOD = 63;
  localparam int unsigned RESET_GAP  = 2500;

endpackage

// File: rtl/neo_pixel_driver_if.sv
// Load/send handshake between the pattern producer and the NeoPixel driver.
interface neo_pixel_driver_if;

  logic       load_color;
  logic [2:0] pixel_index;
  logic [1:0] color_index;
  logic [7:0] color_level;
  logic       send_it;
  logic       ready_to_load;
  logic       ready_to_send;

  modport master (
    output load_color, pixel_index, color_index, color_level, send_it,
    input  ready_to_load, ready_to_send
  );

  modport slave (
    input  load_color, pixel_index, color_index, color_level, send_it,
    output ready_to_load, ready_to_send
  );

endinterface

// File: rtl/neo_bit_timer.sv
// Single-bit waveform generator: a start strobe launches one bit period with the
// line high for T1H or T0H cycles; bit_done flags the final cycle of the period.
// start may be raised on the bit_done cycle to chain bits without a gap.
module neo_bit_timer #(
  parameter int unsigned T0H        = neo_pkg::T0H,
  parameter int unsigned T1H        = neo_pkg::T1H,
  parameter int unsigned BIT_PERIOD = neo_pkg::BIT_PERIOD
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic bit_val,
  output logic level,
  output logic fall,
  output logic bit_done
);

  localparam int unsigned CntW = $clog2(BIT_PERIOD + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(BIT_PERIOD - 1);
  localparam logic [CntW-1:0] HighOne = CntW'(T1H);
  localparam logic [CntW-1:0] HighZero = CntW'(T0H);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_inc;
  logic [CntW-1:0] high_len;
  logic            one_q;
  logic            active_q;
  logic            level_q;

  // Period bookkeeping and the strobes the driver FSM reacts to.
  always_comb begin
    cnt_inc  = cnt_q + 1'b1;
    high_len = one_q ? HighOne : HighZero;
    bit_done = active_q && (cnt_q == LastCnt);
    fall     = active_q && level_q && (cnt_inc >= high_len);
    level    = level_q;
  end

  // Per-bit counter and registered line level.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      one_q    <= 1'b0;
      active_q <= 1'b0;
      level_q  <= 1'b0;
    end else if (start) begin
      cnt_q    <= '0;
      one_q    <= bit_val;
      active_q <= 1'b1;
      level_q  <= 1'b1;
    end else if (bit_done) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      level_q  <= 1'b0;
    end else if (active_q) begin
      cnt_q   <= cnt_inc;
      level_q <= (cnt_inc < high_len);
    end
  end

endmodule

// File: rtl/neo_pixel_driver.sv
// WS2812-style strip driver: holds GRB bytes per pixel and serialises the whole
// frame (pixel 0 first, G/R/B, MSB first) followed by a low latch gap.
// Optional macro NEO_PIXEL_SHADOW_BUFFER_EN adds a shadow memory that accepts
// loads in any state and is copied into the active memory when a send starts.
module neo_pixel_driver #(
  parameter int unsigned NUM_PIXELS = 5,
  parameter int unsigned T0H        = neo_pkg::T0H,
  parameter int unsigned T1H        = neo_pkg::T1H,
  parameter int unsigned BIT_PERIOD = neo_pkg::BIT_PERIOD,
  parameter int unsigned RESET_GAP  = neo_pkg::RESET_GAP
) (
  input  logic              clock,
  input  logic              reset,
  neo_pixel_driver_if.slave bus,
  output logic              neo_data
);

  import neo_pkg::*;

  localparam int unsigned GapW = $clog2(RESET_GAP);
  localparam logic [GapW-1:0] LastGap = GapW'(RESET_GAP - 1);
  localparam logic [2:0] LastPix = 3'(NUM_PIXELS - 1);

  typedef logic [NUM_PIXELS-1:0][2:0][7:0] mem_t;

  state_e    state_q, state_d;
  mem_t      mem_q, mem_d;
  logic [2:0] pix_q, pix_d;
  logic [1:0] byte_q, byte_d;
  logic [2:0] bit_q, bit_d;
  logic [GapW-1:0] gap_q, gap_d;

  logic wr_ok;
  logic start;
  logic bit_val;
  logic fall;
  logic bit_done;
  logic last_bit;

`ifdef NEO_PIXEL_SHADOW_BUFFER_EN
  mem_t shadow_q, shadow_d;
`endif

  neo_bit_timer #(
    .T0H        (T0H),
    .T1H        (T1H),
    .BIT_PERIOD (BIT_PERIOD)
  ) u_bit_timer (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bit_val  (bit_val),
    .level    (neo_data),
    .fall     (fall),
    .bit_done (bit_done)
  );

  // Memory next-state, FSM transitions and serial counter advance.
  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    pix_d   = pix_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    start   = 1'b0;

    wr_ok = bus.load_color && (color_e'(bus.color_index) != NONE) &&
            (32'(bus.pixel_index) < NUM_PIXELS);
    last_bit = (pix_q == LastPix) && (byte_q == 2'd2) && (bit_q == 3'd7);

`ifdef NEO_PIXEL_SHADOW_BUFFER_EN
    shadow_d = shadow_q;
    if (wr_ok) shadow_d[bus.pixel_index][bus.color_index] = bus.color_level;
    // Same-edge loads are part of the copy, so the frame sees them.
    if (state_q == StIdle && bus.send_it) mem_d = shadow_d;
`else
    if (state_q == StIdle && wr_ok) mem_d[bus.pixel_index][bus.color_index] = bus.color_level;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.send_it) begin
          pix_d   = '0;
          byte_d  = '0;
          bit_d   = '0;
          start   = 1'b1;
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (fall) state_d = StLow;
      end
      StLow: begin
        if (bit_done) begin
          if (last_bit) begin
            gap_d   = '0;
            state_d = StLatch;
          end else begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              if (byte_q == 2'd2) begin
                byte_d = '0;
                pix_d  = pix_q + 3'd1;
              end else begin
                byte_d = byte_q + 2'd1;
              end
            end
            start   = 1'b1;
            state_d = StHigh;
          end
        end
      end
      StLatch: begin
        if (gap_q == LastGap) state_d = StIdle;
        else gap_d = gap_q + 1'b1;
      end
    endcase

    // Looked up from next-state memory so a same-edge load reaches the first bit.
    bit_val = mem_d[pix_d][byte_d][~bit_d];
  end

  // Moore readiness decoded from the state register.
  always_comb begin
    bus.ready_to_send = (state_q == StIdle);
`ifdef NEO_PIXEL_SHADOW_BUFFER_EN
    bus.ready_to_load = ~reset;
`else
    bus.ready_to_load = (state_q == StIdle);
`endif
  end

  // State, counters and pixel memory; reset opens with a full latch gap.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StLatch;
      mem_q   <= '0;
      pix_q   <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      pix_q   <= pix_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
    end
  end

`ifdef NEO_PIXEL_SHADOW_BUFFER_EN
  // Shadow copy of the pixel memory, written in every state.
  always_ff @(posedge clock) begin
    if (reset) shadow_q <= '0;
    else shadow_q <= shadow_d;
  end
`endif

endmodule

// File: tb/tb_neo_pixel_driver.sv
// Randomised self-checking bench: a per-pixel byte model predicts every bit's
// high time on the line and the latch gap that follows each frame.
module tb_neo_pixel_driver;

  localparam int NUM = 5;
  localparam int T0H_C = 18;
  localparam int T1H_C = 35;
  localparam int PERIOD = 63;
  localparam int GAP = 2500;
`ifdef NEO_PIXEL_SHADOW_BUFFER_EN
  localparam bit ShadowEn = 1'b1;
`else
  localparam bit ShadowEn = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic neo_data;

  neo_pixel_driver_if bus_if ();

  neo_pixel_driver dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus_if),
    .neo_data (neo_data)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Bytes the next frame should carry: writes land here when the block accepts them.
  byte unsigned pend [8][3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < 3; c++) pend[p][c] = 8'h00;
  endtask

  task automatic model_write(input int p, input int c, input int v, input bit idle);
    if (c != 3 && p < NUM && (idle || ShadowEn)) pend[p][c] = 8'(v);
  endtask

  task automatic drive_load(input int p, input int c, input int v);
    bus_if.load_color  = 1'b1;
    bus_if.pixel_index = 3'(p);
    bus_if.color_index = 2'(c);
    bus_if.color_level = 8'(v);
  endtask

  // Single idle-time write occupying one clock.
  task automatic load(input int p, input int c, input int v);
    drive_load(p, c, v);
    model_write(p, c, v, 1'b1);
    @(negedge clock);
    bus_if.load_color = 1'b0;
  endtask

  // Called at the sample point of latch cycle 0.
  task automatic check_latch(input string tag);
    int bad = 0;
    for (int t = 0; t < GAP; t++) begin
      if (neo_data !== 1'b0 || bus_if.ready_to_send !== 1'b0) bad++;
      @(negedge clock);
    end
    check_eq({tag, "_gap_errs"}, bad, 0);
    check_eq({tag, "_rdy_send"}, bus_if.ready_to_send, 1);
    check_eq({tag, "_rdy_load"}, bus_if.ready_to_load, 1);
  endtask

  task automatic run_frame(input string tag, input bit with_load, input int lp, input int lc,
                           input int lv, input int inj_bit, input int ip, input int ic,
                           input int iv, input int abort_bit);
    byte unsigned snap [8][3];
    int shape_bad = 0;
    int hi;
    int exp_hi;
    int p, c, k;
    check_eq({tag, "_rdy_pre"}, bus_if.ready_to_send, 1);
    if (with_load) begin
      drive_load(lp, lc, lv);
      model_write(lp, lc, lv, 1'b1);
    end
    bus_if.send_it = 1'b1;
    snap = pend;
    @(negedge clock);
    bus_if.send_it = 1'b0;
    bus_if.load_color = 1'b0;
    for (int b = 0; b < 24 * NUM; b++) begin
      p = b / 24;
      c = (b % 24) / 8;
      k = b % 8;
      exp_hi = ((snap[p][c] >> (7 - k)) & 1) != 0 ? T1H_C : T0H_C;
      if (b == abort_bit) begin
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq({tag, "_abort_data"}, neo_data, 0);
        check_eq({tag, "_abort_rdy"}, bus_if.ready_to_send, 0);
        model_clear();
        check_latch({tag, "_abort"});
        return;
      end
      hi = 0;
      for (int t = 0; t < PERIOD; t++) begin
        if (neo_data === 1'b1) begin
          if (hi != t) shape_bad++;
          hi++;
        end else if (neo_data !== 1'b0) begin
          shape_bad++;
        end
        if (b == inj_bit && t == 5) begin
          check_eq({tag, "_rdy_load_busy"}, bus_if.ready_to_load, ShadowEn);
          check_eq({tag, "_rdy_send_busy"}, bus_if.ready_to_send, 0);
          drive_load(ip, ic, iv);
          model_write(ip, ic, iv, 1'b0);
          bus_if.send_it = 1'b1;
        end
        if (b == inj_bit && t == 6) begin
          bus_if.load_color = 1'b0;
          bus_if.send_it = 1'b0;
        end
        @(negedge clock);
      end
      check_eq($sformatf("%s_bit%0d_high", tag, b), hi, exp_hi);
    end
    check_eq({tag, "_shape_errs"}, shape_bad, 0);
    check_latch(tag);
  endtask

  initial begin
    int p, c, v;
    bus_if.load_color  = 1'b0;
    bus_if.pixel_index = '0;
    bus_if.color_index = '0;
    bus_if.color_level = '0;
    bus_if.send_it     = 1'b0;
    model_clear();

    // Reset: three edges, then the initial latch gap.
    repeat (3) @(negedge clock);
    check_eq("reset_data", neo_data, 0);
    check_eq("reset_rdy_send", bus_if.ready_to_send, 0);
    check_eq("reset_rdy_load", bus_if.ready_to_load, ShadowEn ? 0 : 0);
    reset = 1'b0;
    check_latch("init");

    // Single 1 bit at the very start of the frame.
    load(0, 0, 8'h80);
    run_frame("g80", 1'b0, 0, 0, 0, -1, 0, 0, 0, -1);

    // Out-of-range pixel and no-op byte slot must not touch memory.
    load(0, 0, 8'h00);
    load(6, 0, 8'hFF);
    load(7, 1, 8'hA5);
    load(2, 3, 8'hFF);
    run_frame("ignored", 1'b0, 0, 0, 0, -1, 0, 0, 0, -1);

    // Load and send on the same edge: last byte of the frame is all ones.
    run_frame("same_edge", 1'b1, 4, 2, 8'hFF, -1, 0, 0, 0, -1);

    // Load and send pulsed mid-frame; the frame in flight is unaffected.
    run_frame("busy_load", 1'b0, 0, 0, 0, 10, 0, 1, 8'hAA, -1);
    run_frame("after_busy", 1'b0, 0, 0, 0, -1, 0, 0, 0, -1);

    // Reset in the middle of bit 50.
    load(1, 1, 8'h3C);
    run_frame("abort", 1'b0, 0, 0, 0, -1, 0, 0, 0, 50);

    // Random loads, including invalid targets, on top of the cleared memory.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin
        p = $urandom_range(0, 7);
        c = $urandom_range(0, 3);
        v = $urandom_range(0, 255);
        load(p, c, v);
      end
      p = $urandom_range(0, 4);
      c = $urandom_range(0, 2);
      v = $urandom_range(0, 255);
      run_frame($sformatf("rand%0d", f), 1'($urandom_range(0, 1)), p, c, v, -1, 0, 0, 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/neo_pixel_driver.md
Name: neo_pixel_driver

Overview:
- Downstream consumer of the pixel-pattern producer.
- Stores per-pixel GRB colour bytes written over a load handshake.
- On request, serialises all pixels onto the single-wire WS2812-style `neo_data` line, then holds the line low for the latch gap.
- Reports readiness back to the producer via `ready_to_load` and `ready_to_send`.

Parameters:
- NUM_PIXELS, 5: pixels in the strip. Must be ≤ 8, to match the 3-bit `pixel_index`.
- T0H, 18: clock cycles `neo_data` is high for a 0 bit (0.36 us at 50 MHz).
- T1H, 35: clock cycles `neo_data` is high for a 1 bit (0.70 us).
- BIT_PERIOD, 63: total clock cycles per bit (1.26 us). Must be greater than T1H.
- RESET_GAP, 2500: clock cycles of low line after a frame (50 us).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- load_color  in  1  write strobe; colour byte is written on the edge where it is sampled high.
- pixel_index  in  3  target pixel for the write.
- color_index  in  2  target byte: 0 green, 1 red, 2 blue, 3 no-op.
- color_level  in  8  colour byte value.
- send_it  in  1  request to transmit the whole frame.
- ready_to_load  out  1  block accepts `load_color` this cycle.
- ready_to_send  out  1  block accepts `send_it` this cycle.
- neo_data  out  1  serial LED line, registered.

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on the rising edge of `clock`.
- Reset:
  - Pixel memory cleared to 0x00.
  - `neo_data` = 0; `ready_to_load` = 0; `ready_to_send` = 0.
  - FSM goes to LATCH with the gap counter = 0, so the strip sees an initial latch.
- `ready_*` are Moore outputs decoded from the state register. Both are 1 only in IDLE.
- FSM states: IDLE, HIGH, LOW, LATCH.
- IDLE:
  - `load_color` = 1 and `color_index` ≠ 3 and `pixel_index` < NUM_PIXELS: write `mem[pixel_index][color_index] <= color_level`. Otherwise the write is ignored.
  - `send_it` = 1: clear the pixel, byte and bit counters; go to HIGH. `neo_data` goes 1 on the same edge.
  - `load_color` and `send_it` together: the write commits, and the frame transmits the new value.
- Transmit order:
  - Pixels 0 to NUM_PIXELS-1.
  - Within each pixel, bytes green, red, blue.
  - Within each byte, MSB first.
  - Total 24·NUM_PIXELS bits.
- Bit timing:
  - A per-bit cycle counter runs 0 to BIT_PERIOD-1.
  - `neo_data` = 1 while count < (bit ? T1H : T0H), else 0.
  - HIGH→LOW when the high time expires.
  - At count = BIT_PERIOD-1, advance to the next bit, staying in HIGH with `neo_data` = 1. After the last bit, go to LATCH.
- LATCH:
  - `neo_data` = 0 for exactly RESET_GAP cycles, then IDLE.
- Frame length: `send_it` accepted at edge k → `neo_data` rises at edge k. IDLE is re-entered after 24·NUM_PIXELS·BIT_PERIOD + RESET_GAP cycles.
- Outside IDLE, `load_color` and `send_it` are ignored (unless the optional feature is enabled).
- Reset mid-frame:
  - `neo_data` drops next edge.
  - Memory is cleared.
  - A full latch gap precedes readiness.

Optional Feature:
- Macro: NEO_PIXEL_SHADOW_BUFFER_EN.
- Enabled:
  - A second (shadow) memory receives all writes.
  - `ready_to_load` = 1 in every state except during reset.
  - Loads during HIGH, LOW or LATCH land in the shadow and do not disturb the frame in flight.
  - On `send_it` acceptance, shadow copies into the active memory in one cycle; the frame uses the copied values. A `load_color` on that same edge is included in the copy.
- Disabled: single memory; behaviour exactly as above.

Decomposition:
- Package `neo_pkg`:
  - `color_e` enum (GREEN = 0, RED = 1, BLUE = 2, NONE = 3).
  - Driver FSM state enum.
  - Default timing localparams T0H, T1H, BIT_PERIOD, RESET_GAP.
- Sub-module `neo_bit_timer`: given bit value and start strobe, produces the line level and a `bit_done` pulse. It owns the BIT_PERIOD counter.
- Top level owns memory, pixel/byte/bit counters, FSM and the latch counter.

Test Plan:
- Reset release → `neo_data` = 0 and `ready_to_send` = 0 for 2500 cycles, then `ready_to_load` = `ready_to_send` = 1.
- Load pixel0 G = 0x80, all else 0; `send_it` → first bit high 35 cycles, low 28; the next 119 bits each high 18 cycles, low 45; then 2500 low cycles and ready again.
- Loads with `pixel_index` = 6, and with `color_index` = 3 → memory unchanged; the full frame shows all 0 bits.
- `load_color` (pixel4 B = 0xFF) and `send_it` in the same cycle → the last 8 bits of the frame are 1s.
- `load_color` pulsed during HIGH → ignored when the macro is off. With the macro on, the value appears in the next frame, not the current one.
- Reset asserted mid-frame at bit 50 → `neo_data` = 0 next edge, memory zeroed, ready after 2500 cycles.
